// File: rtl/simmem_pkg.sv
// Shared types for the simulated memory responder: request/response
// payloads and the field widths they are built from.
package simmem_pkg;

  localparam int unsigned IdWidth          = 4;
  localparam int unsigned MaxBurstLenField = 8;
  localparam int unsigned DataWidth        = 32;

  typedef struct packed {
    logic [IdWidth-1:0]          id;
    logic [MaxBurstLenField-1:0] burst_len;
  } raddr_t;

  typedef struct packed {
    logic [IdWidth-1:0] id;
  } waddr_t;

  typedef struct packed {
    logic last;
  } wdata_t;

  typedef struct packed {
    logic [IdWidth-1:0]   id;
    logic [DataWidth-1:0] data;
    logic                 last;
  } rdata_t;

  typedef struct packed {
    logic [IdWidth-1:0] id;
  } wrsp_t;

endpackage

// File: rtl/simmem_resp_fifo.sv
// Small power-of-two FIFO that holds accepted write ids until their
// response can be issued. Pointers wrap naturally because Depth is 2^n.
module simmem_resp_fifo #(
  parameter int unsigned Width = 4,
  parameter int unsigned Depth = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic [Width-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam logic [PtrW:0] CountFull = (PtrW + 1)'(Depth);
  localparam logic [PtrW:0] CountOne  = (PtrW + 1)'(1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]    count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == CountFull);
  assign empty_o = (count_q == '0);
  assign data_o  = mem_q[rd_ptr_q];
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  // Next pointer/occupancy; a coincident push and pop leave the count alone.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    if (push_ok && !pop_ok)      count_d = count_q + CountOne;
    else if (!push_ok && pop_ok) count_d = count_q - CountOne;
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is pure data path; validity is tracked by count_q.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/simmem_mem_responder.sv
// Simulated memory slave: answers reads with a burst of beats whose data
// is the beat index after a fixed latency, and answers writes with an id
// response once both the address and the last data beat have arrived.
module simmem_mem_responder
  import simmem_pkg::*;
#(
  parameter int unsigned RdLatency      = 4,
  parameter int unsigned WAddrFifoDepth = 4
) (
  input  logic   clk_i,
  input  logic   rst_i,
  input  logic   raddr_valid_i,
  output logic   raddr_ready_o,
  input  raddr_t raddr_i,
  input  logic   waddr_valid_i,
  output logic   waddr_ready_o,
  input  waddr_t waddr_i,
  input  logic   wdata_valid_i,
  output logic   wdata_ready_o,
  input  wdata_t wdata_i,
  output logic   rdata_valid_o,
  input  logic   rdata_ready_i,
  output rdata_t rdata_o,
  output logic   wrsp_valid_o,
  input  logic   wrsp_ready_i,
  output wrsp_t  wrsp_o
);

  typedef enum logic [1:0] {RD_IDLE, RD_WAIT, RD_BURST} rd_state_e;

  localparam logic [7:0] LatInit = 8'(RdLatency - 1);
  localparam int unsigned CntW = $clog2(WAddrFifoDepth + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(WAddrFifoDepth);
  localparam logic [CntW-1:0] CntOne = CntW'(1);

  // ---------------- read side ----------------
  rd_state_e                   state_q;
  logic [7:0]                  lat_q;
  logic [IdWidth-1:0]          rd_id_q;
  logic [MaxBurstLenField-1:0] len_q;
  logic [MaxBurstLenField-1:0] beat_q;

  // Read FSM: capture the request, count the latency down, then stream beats.
  // The wait state leaves as its counter reaches zero so the first beat lands
  // exactly RdLatency cycles after the address handshake; latency 1 skips it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= RD_IDLE;
      lat_q   <= '0;
      rd_id_q <= '0;
      len_q   <= '0;
      beat_q  <= '0;
    end else begin
      unique case (state_q)
        RD_IDLE: begin
          if (raddr_valid_i) begin
            rd_id_q <= raddr_i.id;
            len_q   <= raddr_i.burst_len;
            beat_q  <= '0;
            lat_q   <= LatInit;
            state_q <= (RdLatency == 1) ? RD_BURST : RD_WAIT;
          end
        end
        RD_WAIT: begin
          lat_q <= lat_q - 8'd1;
          if (lat_q == 8'd1) state_q <= RD_BURST;
        end
        RD_BURST: begin
          if (rdata_ready_i) begin
            if (beat_q == len_q) state_q <= RD_IDLE;
            else                 beat_q  <= beat_q + MaxBurstLenField'(1);
          end
        end
        default: state_q <= RD_IDLE;
      endcase
    end
  end

  assign raddr_ready_o = (state_q == RD_IDLE);
  assign rdata_valid_o = (state_q == RD_BURST);
  assign rdata_o.id    = rd_id_q;
  assign rdata_o.data  = DataWidth'(beat_q);
  assign rdata_o.last  = rdata_valid_o && (beat_q == len_q);

  // ---------------- write side ----------------
  logic               fifo_push, fifo_full, fifo_empty;
  logic [IdWidth-1:0] fifo_head;
  logic [CntW-1:0]    wdone_q, wdone_d;
  logic               wdone_inc, rsp_load;
  logic               wrsp_valid_q, wrsp_valid_d;
  logic [IdWidth-1:0] wrsp_id_q, wrsp_id_d;

  assign waddr_ready_o = !fifo_full;
  assign wdata_ready_o = (wdone_q != CntMax);
  assign fifo_push     = waddr_valid_i && waddr_ready_o;
  assign wdone_inc     = wdata_valid_i && wdata_ready_o && wdata_i.last;
  assign rsp_load      = !fifo_empty && (wdone_q != '0) &&
                         (!wrsp_valid_q || wrsp_ready_i);

  simmem_resp_fifo #(
    .Width (IdWidth),
    .Depth (WAddrFifoDepth)
  ) u_waddr_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (fifo_push),
    .data_i  (waddr_i.id),
    .pop_i   (rsp_load),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Completed-burst counter and response register next state; a response
  // load consumes one completed burst and the oldest queued write id.
  always_comb begin
    wdone_d      = wdone_q;
    wrsp_valid_d = wrsp_valid_q;
    wrsp_id_d    = wrsp_id_q;
    if (wdone_inc && !rsp_load)      wdone_d = wdone_q + CntOne;
    else if (!wdone_inc && rsp_load) wdone_d = wdone_q - CntOne;
    if (rsp_load) begin
      wrsp_valid_d = 1'b1;
      wrsp_id_d    = fifo_head;
    end else if (wrsp_ready_i) begin
      wrsp_valid_d = 1'b0;
    end
  end

  // Write-side registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wdone_q      <= '0;
      wrsp_valid_q <= 1'b0;
      wrsp_id_q    <= '0;
    end else begin
      wdone_q      <= wdone_d;
      wrsp_valid_q <= wrsp_valid_d;
      wrsp_id_q    <= wrsp_id_d;
    end
  end

  assign wrsp_valid_o = wrsp_valid_q;
  assign wrsp_o.id    = wrsp_id_q;

endmodule

// File: tb/tb_simmem_mem_responder.sv
// Self-checking bench for simmem_mem_responder: expected read beats and
// write-response ids are queued when stimulus is driven and checked as the
// DUT emits them.
module tb_simmem_mem_responder;
  import simmem_pkg::*;

  localparam int unsigned RdLat = 4;
  localparam int unsigned Depth = 4;

  logic   clk_i = 1'b0;
  logic   rst_i;
  logic   raddr_valid_i, raddr_ready_o;
  raddr_t raddr_i;
  logic   waddr_valid_i, waddr_ready_o;
  waddr_t waddr_i;
  logic   wdata_valid_i, wdata_ready_o;
  wdata_t wdata_i;
  logic   rdata_valid_o, rdata_ready_i;
  rdata_t rdata_o;
  logic   wrsp_valid_o, wrsp_ready_i;
  wrsp_t  wrsp_o;

  int testsRun = 0;
  int testsFailed = 0;
  rdata_t rdQ[$];
  logic [IdWidth-1:0] wrQ[$];

  simmem_mem_responder #(
    .RdLatency      (RdLat),
    .WAddrFifoDepth (Depth)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .raddr_valid_i (raddr_valid_i),
    .raddr_ready_o (raddr_ready_o),
    .raddr_i       (raddr_i),
    .waddr_valid_i (waddr_valid_i),
    .waddr_ready_o (waddr_ready_o),
    .waddr_i       (waddr_i),
    .wdata_valid_i (wdata_valid_i),
    .wdata_ready_o (wdata_ready_o),
    .wdata_i       (wdata_i),
    .rdata_valid_o (rdata_valid_o),
    .rdata_ready_i (rdata_ready_i),
    .rdata_o       (rdata_o),
    .wrsp_valid_o  (wrsp_valid_o),
    .wrsp_ready_i  (wrsp_ready_i),
    .wrsp_o        (wrsp_o)
  );

  // Free-running clock; inputs change and outputs are sampled on negedges.
  always #5 clk_i = ~clk_i;

  // Hard stop in case something unforeseen stalls the sequence.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(negedge clk_i);
  endtask

  task automatic idleInputs();
    raddr_valid_i = 1'b0;
    raddr_i       = '0;
    waddr_valid_i = 1'b0;
    waddr_i       = '0;
    wdata_valid_i = 1'b0;
    wdata_i       = '0;
    rdata_ready_i = 1'b0;
    wrsp_ready_i  = 1'b0;
  endtask

  // Reset pulse for one edge; leaves the bench on the following negedge.
  task automatic applyReset();
    idleInputs();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    rdQ.delete();
    wrQ.delete();
  endtask

  // Reset with every request valid: reset must win over the handshakes.
  task automatic test_reset();
    rst_i = 1'b1;
    raddr_valid_i = 1'b1; raddr_i.id = 4'd5; raddr_i.burst_len = 8'd1;
    waddr_valid_i = 1'b1; waddr_i.id = 4'd6;
    wdata_valid_i = 1'b1; wdata_i.last = 1'b1;
    rdata_ready_i = 1'b1; wrsp_ready_i = 1'b1;
    tick();
    tick();
    rst_i = 1'b0;
    idleInputs();
    testsRun++; if (raddr_ready_o !== 1'b1) begin testsFailed++; $display("[TB] FAIL reset_raddr_ready got %b want 1", raddr_ready_o); end
    testsRun++; if (waddr_ready_o !== 1'b1) begin testsFailed++; $display("[TB] FAIL reset_waddr_ready got %b want 1", waddr_ready_o); end
    testsRun++; if (wdata_ready_o !== 1'b1) begin testsFailed++; $display("[TB] FAIL reset_wdata_ready got %b want 1", wdata_ready_o); end
    testsRun++; if (rdata_valid_o !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_rdata_valid got %b want 0", rdata_valid_o); end
    testsRun++; if (wrsp_valid_o !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_wrsp_valid got %b want 0", wrsp_valid_o); end
    testsRun++; if (rdata_o !== '0) begin testsFailed++; $display("[TB] FAIL reset_rdata got %h want 0", rdata_o); end
    testsRun++; if (wrsp_o !== '0) begin testsFailed++; $display("[TB] FAIL reset_wrsp got %h want 0", wrsp_o); end
  endtask

  // id 3, burst_len 2, ready held high: beats 0,1,2 starting RdLat cycles later.
  task automatic test_read_burst();
    rdata_t exp;
    int k;
    int firstK;
    for (int b = 0; b <= 2; b++) begin
      exp.id = 4'd3; exp.data = 32'(b); exp.last = (b == 2);
      rdQ.push_back(exp);
    end
    raddr_i.id = 4'd3; raddr_i.burst_len = 8'd2;
    raddr_valid_i = 1'b1; rdata_ready_i = 1'b1;
    testsRun++; if (raddr_ready_o !== 1'b1) begin testsFailed++; $display("[TB] FAIL burst_raddr_ready_idle got %b want 1", raddr_ready_o); end
    tick();
    raddr_valid_i = 1'b0;
    k = 1;
    firstK = -1;
    while (rdQ.size() > 0 && k <= 20) begin
      testsRun++; if (raddr_ready_o !== 1'b0) begin testsFailed++; $display("[TB] FAIL burst_raddr_ready_busy cycle %0d got %b want 0", k, raddr_ready_o); end
      if (rdata_valid_o === 1'b1) begin
        if (firstK < 0) firstK = k;
        exp = rdQ.pop_front();
        testsRun++; if (rdata_o !== exp) begin testsFailed++; $display("[TB] FAIL burst_beat got %h want %h", rdata_o, exp); end
      end
      tick();
      k++;
    end
    testsRun++; if (rdQ.size() != 0) begin testsFailed++; $display("[TB] FAIL burst_timeout got %0d beats left want 0", rdQ.size()); end
    testsRun++; if (firstK != int'(RdLat)) begin testsFailed++; $display("[TB] FAIL burst_latency got %0d want %0d", firstK, RdLat); end
    testsRun++; if (raddr_ready_o !== 1'b1) begin testsFailed++; $display("[TB] FAIL burst_raddr_ready_after got %b want 1", raddr_ready_o); end
    testsRun++; if (rdata_valid_o !== 1'b0) begin testsFailed++; $display("[TB] FAIL burst_valid_after got %b want 0", rdata_valid_o); end
    rdata_ready_i = 1'b0;
  endtask

  // burst_len 0 with the consumer stalled: one beat, held stable, last high.
  task automatic test_read_stall();
    rdata_t exp;
    int k;
    exp.id = 4'd6; exp.data = 32'd0; exp.last = 1'b1;
    rdQ.push_back(exp);
    raddr_i.id = 4'd6; raddr_i.burst_len = 8'd0;
    raddr_valid_i = 1'b1; rdata_ready_i = 1'b0;
    tick();
    raddr_valid_i = 1'b0;
    k = 0;
    while (rdata_valid_o !== 1'b1 && k < 20) begin tick(); k++; end
    testsRun++; if (rdata_valid_o !== 1'b1) begin testsFailed++; $display("[TB] FAIL stall_timeout got valid %b want 1", rdata_valid_o); end
    for (int c = 0; c < 5; c++) begin
      testsRun++; if (rdata_valid_o !== 1'b1 || rdata_o !== rdQ[0]) begin testsFailed++; $display("[TB] FAIL stall_hold cycle %0d got %b/%h want 1/%h", c, rdata_valid_o, rdata_o, rdQ[0]); end
      tick();
    end
    rdata_ready_i = 1'b1;
    exp = rdQ.pop_front();
    testsRun++; if (rdata_o !== exp) begin testsFailed++; $display("[TB] FAIL stall_accept got %h want %h", rdata_o, exp); end
    tick();
    rdata_ready_i = 1'b0;
    testsRun++; if (rdata_valid_o !== 1'b0) begin testsFailed++; $display("[TB] FAIL stall_single_beat got %b want 0", rdata_valid_o); end
    testsRun++; if (raddr_ready_o !== 1'b1) begin testsFailed++; $display("[TB] FAIL stall_idle got %b want 1", raddr_ready_o); end
  endtask

  // Ids 1,2,5 first, then three last beats: responses in address order,
  // the first one two cycles after the first last beat.
  task automatic test_write_order();
    logic [IdWidth-1:0] ids [3];
    logic [IdWidth-1:0] exp;
    int firstJ;
    int j;
    ids[0] = 4'd1; ids[1] = 4'd2; ids[2] = 4'd5;
    wrsp_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      waddr_i.id = ids[i];
      waddr_valid_i = 1'b1;
      wrQ.push_back(ids[i]);
      tick();
    end
    waddr_valid_i = 1'b0;
    firstJ = -1;
    j = 0;
    while (wrQ.size() > 0 && j < 20) begin
      if (wrsp_valid_o === 1'b1) begin
        if (firstJ < 0) firstJ = j;
        exp = wrQ.pop_front();
        testsRun++; if (wrsp_o.id !== exp) begin testsFailed++; $display("[TB] FAIL worder_id got %0d want %0d", wrsp_o.id, exp); end
      end
      wdata_valid_i = (j < 3);
      wdata_i.last  = 1'b1;
      tick();
      j++;
    end
    wdata_valid_i = 1'b0;
    testsRun++; if (wrQ.size() != 0) begin testsFailed++; $display("[TB] FAIL worder_timeout got %0d left want 0", wrQ.size()); end
    testsRun++; if (firstJ != 2) begin testsFailed++; $display("[TB] FAIL worder_latency got %0d want 2", firstJ); end
  endtask

  // Five addresses with no data: queue fills at Depth, frees after one pop.
  task automatic test_waddr_full();
    int accepted;
    accepted = 0;
    wrsp_ready_i = 1'b0;
    for (int c = 0; c < 8; c++) begin
      if (accepted < 5) begin
        waddr_valid_i = 1'b1;
        waddr_i.id = 4'(7 + accepted);
        if (waddr_ready_o === 1'b1) begin
          wrQ.push_back(4'(7 + accepted));
          accepted++;
        end
      end else begin
        waddr_valid_i = 1'b0;
      end
      tick();
    end
    waddr_valid_i = 1'b0;
    testsRun++; if (accepted != int'(Depth)) begin testsFailed++; $display("[TB] FAIL wfull_accepts got %0d want %0d", accepted, Depth); end
    testsRun++; if (waddr_ready_o !== 1'b0) begin testsFailed++; $display("[TB] FAIL wfull_ready_low got %b want 0", waddr_ready_o); end
    wdata_valid_i = 1'b1; wdata_i.last = 1'b1;
    tick();
    wdata_valid_i = 1'b0;
    testsRun++; if (waddr_ready_o !== 1'b0) begin testsFailed++; $display("[TB] FAIL wfull_ready_before_pop got %b want 0", waddr_ready_o); end
    tick();
    testsRun++; if (waddr_ready_o !== 1'b1) begin testsFailed++; $display("[TB] FAIL wfull_ready_after_pop got %b want 1", waddr_ready_o); end
    testsRun++; if (wrsp_valid_o !== 1'b1 || wrsp_o.id !== wrQ[0]) begin testsFailed++; $display("[TB] FAIL wfull_rsp got %b/%0d want 1/%0d", wrsp_valid_o, wrsp_o.id, wrQ[0]); end
    void'(wrQ.pop_front());
  endtask

  // Five last beats with no address: counter saturates, no response until
  // an address arrives.
  task automatic test_wdata_sat();
    int acc;
    int sawRsp;
    acc = 0;
    sawRsp = 0;
    wrsp_ready_i = 1'b1;
    for (int c = 0; c < 8; c++) begin
      if (wrsp_valid_o !== 1'b0) sawRsp++;
      wdata_valid_i = (c < 5);
      wdata_i.last = 1'b1;
      if (c < 5 && wdata_ready_o === 1'b1) acc++;
      tick();
    end
    wdata_valid_i = 1'b0;
    if (wrsp_valid_o !== 1'b0) sawRsp++;
    testsRun++; if (acc != int'(Depth)) begin testsFailed++; $display("[TB] FAIL wsat_accepts got %0d want %0d", acc, Depth); end
    testsRun++; if (wdata_ready_o !== 1'b0) begin testsFailed++; $display("[TB] FAIL wsat_ready_low got %b want 0", wdata_ready_o); end
    testsRun++; if (sawRsp != 0) begin testsFailed++; $display("[TB] FAIL wsat_no_rsp got %0d want 0", sawRsp); end
    waddr_i.id = 4'd9;
    waddr_valid_i = 1'b1;
    wrQ.push_back(4'd9);
    tick();
    waddr_valid_i = 1'b0;
    testsRun++; if (wrsp_valid_o !== 1'b0) begin testsFailed++; $display("[TB] FAIL wsat_rsp_early got %b want 0", wrsp_valid_o); end
    tick();
    testsRun++; if (wrsp_valid_o !== 1'b1 || wrsp_o.id !== wrQ[0]) begin testsFailed++; $display("[TB] FAIL wsat_rsp got %b/%0d want 1/%0d", wrsp_valid_o, wrsp_o.id, wrQ[0]); end
    void'(wrQ.pop_front());
    testsRun++; if (wdata_ready_o !== 1'b1) begin testsFailed++; $display("[TB] FAIL wsat_ready_back got %b want 1", wdata_ready_o); end
  endtask

  // Reset on the second beat of a burst_len 3 read aborts the burst.
  task automatic test_reset_mid_burst();
    int k;
    int stale;
    raddr_i.id = 4'd2; raddr_i.burst_len = 8'd3;
    raddr_valid_i = 1'b1; rdata_ready_i = 1'b1;
    tick();
    raddr_valid_i = 1'b0;
    k = 0;
    while (rdata_valid_o !== 1'b1 && k < 20) begin tick(); k++; end
    testsRun++; if (rdata_valid_o !== 1'b1) begin testsFailed++; $display("[TB] FAIL midrst_timeout got valid %b want 1", rdata_valid_o); end
    tick();
    testsRun++; if (rdata_valid_o !== 1'b1 || rdata_o.data !== 32'd1) begin testsFailed++; $display("[TB] FAIL midrst_second_beat got %b/%0d want 1/1", rdata_valid_o, rdata_o.data); end
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    testsRun++; if (rdata_valid_o !== 1'b0) begin testsFailed++; $display("[TB] FAIL midrst_valid got %b want 0", rdata_valid_o); end
    testsRun++; if (raddr_ready_o !== 1'b1) begin testsFailed++; $display("[TB] FAIL midrst_raddr_ready got %b want 1", raddr_ready_o); end
    stale = 0;
    for (int c = 0; c < 12; c++) begin
      if (rdata_valid_o !== 1'b0) stale++;
      tick();
    end
    testsRun++; if (stale != 0) begin testsFailed++; $display("[TB] FAIL midrst_stale_beats got %0d want 0", stale); end
    rdata_ready_i = 1'b0;
  endtask

  // Run the scenarios in order, resetting between the write scenarios so
  // each starts from an empty queue and a zero counter.
  initial begin
    idleInputs();
    rst_i = 1'b1;
    tick();
    test_reset();
    test_read_burst();
    test_read_stall();
    applyReset();
    test_write_order();
    applyReset();
    test_waddr_full();
    applyReset();
    test_wdata_sat();
    applyReset();
    test_reset_mid_burst();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
